puf_uart_sequencer: RTL and testbench

//  Parametrised challenge/response sequencer between a byte-stream UART (uart_rx/uart_tx) and an arbiter PUF.

---
 rtl/puf_ctrl_pkg.sv | 19 +
 rtl/puf_uart_sequencer_if.sv | 30 +++
 rtl/puf_vote_acc.sv | 37 +++
 rtl/puf_uart_sequencer.sv | 170 +++++++++++++++++
 tb/tb_puf_uart_sequencer.sv | 219 +++++++++++++++++++++
 5 files changed

// File: rtl/puf_ctrl_pkg.sv
// Shared types and helpers for the PUF challenge/response sequencer.
package puf_ctrl_pkg;

  localparam int unsigned BYTE_W = 8;

  typedef enum logic [2:0] {
    S_RX,
    S_PRE,
    S_EVAL,
    S_VOTE,
    S_TX
  } state_e;

  // Bits needed to hold any value in 0..max_val (never less than one bit).
  function automatic int unsigned cnt_w(input int unsigned max_val);
    return (max_val == 0) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/puf_uart_sequencer_if.sv
// Byte-stream UART side and arbiter PUF side of the sequencer.
interface puf_uart_sequencer_if #(
  parameter int unsigned CHAL_W = 64,
  parameter int unsigned RESP_W = 64
);
  import puf_ctrl_pkg::*;

  logic              rx_valid;
  logic [BYTE_W-1:0] rx_data;
  logic              tx_valid;
  logic [BYTE_W-1:0] tx_data;
  logic              tx_ready;
  logic [CHAL_W-1:0] puf_challenge;
  logic              puf_signal;
  logic [RESP_W-1:0] puf_response;
  logic              busy;
  logic              overrun;

  // Sequencer side.
  modport master (
    input  rx_valid, rx_data, tx_ready, puf_response,
    output tx_valid, tx_data, puf_challenge, puf_signal, busy, overrun
  );

  // UART/PUF side.
  modport slave (
    output rx_valid, rx_data, tx_ready, puf_response,
    input  tx_valid, tx_data, puf_challenge, puf_signal, busy, overrun
  );
endinterface

// File: rtl/puf_vote_acc.sv
// Per-bit ones counters over PUF samples, with majority decision.
module puf_vote_acc
  import puf_ctrl_pkg::*;
#(
  parameter int unsigned RESP_W      = 64,
  parameter int unsigned NUM_SAMPLES = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              add,
  input  logic [RESP_W-1:0] resp,
  output logic [RESP_W-1:0] majority
);

  localparam int unsigned VW = cnt_w(NUM_SAMPLES);

  logic [VW-1:0] cnt_q [RESP_W];

  // Accumulate one sample per add; clr takes priority.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < RESP_W; i++) cnt_q[i] <= '0;
    end else if (clr) begin
      for (int i = 0; i < RESP_W; i++) cnt_q[i] <= '0;
    end else if (add) begin
      for (int i = 0; i < RESP_W; i++) cnt_q[i] <= cnt_q[i] + VW'(resp[i]);
    end
  end

  // Strict majority: NUM_SAMPLES is odd so there is never a tie.
  always_comb begin
    majority = '0;
    for (int i = 0; i < RESP_W; i++) majority[i] = (cnt_q[i] > VW'(NUM_SAMPLES / 2));
  end

endmodule

// File: rtl/puf_uart_sequencer.sv
// Challenge assembly from UART bytes, timed PUF sampling, majority vote, response return.
module puf_uart_sequencer
  import puf_ctrl_pkg::*;
#(
  parameter int unsigned CHAL_W        = 64,
  parameter int unsigned RESP_W        = 64,
  parameter int unsigned SETTLE_CYCLES = 65536,
  parameter int unsigned NUM_SAMPLES   = 5,
  parameter int unsigned RX_TIMEOUT    = 0
) (
  input logic clk,
  input logic rst_n,
  puf_uart_sequencer_if.master bus
);

  localparam int unsigned CHAL_BYTES = CHAL_W / BYTE_W;
  localparam int unsigned RESP_BYTES = RESP_W / BYTE_W;
  localparam int unsigned BCW = cnt_w(CHAL_BYTES);
  localparam int unsigned PW  = cnt_w(SETTLE_CYCLES - 1);
  localparam int unsigned SW  = cnt_w(NUM_SAMPLES);
  localparam int unsigned TW  = cnt_w(RESP_BYTES);
  localparam int unsigned IW  = cnt_w(RX_TIMEOUT);

  state_e            state_q, state_d;
  logic [BCW-1:0]    byte_cnt_q, byte_cnt_d;
  logic [CHAL_W-1:0] chal_sr_q, chal_sr_d;
  logic [CHAL_W-1:0] chal_q, chal_d;
  logic [PW-1:0]     phase_q, phase_d;
  logic [SW-1:0]     sample_q, sample_d;
  logic [RESP_W-1:0] tx_sr_q, tx_sr_d;
  logic [TW-1:0]     tx_cnt_q, tx_cnt_d;
  logic [IW-1:0]     idle_q, idle_d;
  logic              overrun_q, overrun_d;

  logic              rx_done, phase_last, sample_last, tx_last;
  logic              tx_valid, puf_signal, busy, acc_add, acc_clr;
  logic [RESP_W-1:0] majority;

  assign rx_done     = (state_q == S_RX) && bus.rx_valid && (byte_cnt_q == BCW'(CHAL_BYTES - 1));
  assign phase_last  = (phase_q == PW'(SETTLE_CYCLES - 1));
  assign sample_last = (sample_q == SW'(NUM_SAMPLES - 1));
  assign tx_last     = (state_q == S_TX) && bus.tx_ready && (tx_cnt_q == TW'(RESP_BYTES - 1));

  puf_vote_acc #(
    .RESP_W      (RESP_W),
    .NUM_SAMPLES (NUM_SAMPLES)
  ) u_vote_acc (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (acc_clr),
    .add      (acc_add),
    .resp     (bus.puf_response),
    .majority (majority)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_RX;
    else        state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_RX:    if (rx_done) state_d = S_PRE;
      S_PRE:   if (phase_last) state_d = S_EVAL;
      S_EVAL:  if (phase_last) state_d = sample_last ? S_VOTE : S_PRE;
      S_VOTE:  state_d = S_TX;
      S_TX:    if (tx_last) state_d = S_RX;
      default: state_d = S_RX;
    endcase
  end

  // State-decoded outputs and vote accumulator controls.
  always_comb begin
    tx_valid   = (state_q == S_TX);
    puf_signal = (state_q == S_EVAL);
    busy       = (state_q != S_RX);
    acc_add    = (state_q == S_EVAL) && phase_last;
    acc_clr    = (state_q == S_VOTE);
  end

  // Datapath next-state: rx assembly, timeout, phase/sample counters, tx shifter.
  always_comb begin
    byte_cnt_d = byte_cnt_q;
    chal_sr_d  = chal_sr_q;
    chal_d     = chal_q;
    phase_d    = '0;
    sample_d   = sample_q;
    tx_sr_d    = tx_sr_q;
    tx_cnt_d   = tx_cnt_q;
    idle_d     = '0;
    overrun_d  = bus.rx_valid && (state_q != S_RX);

    unique case (state_q)
      S_RX: begin
        if (bus.rx_valid) begin
          // An accepted byte always wins over a coincident timeout.
          if (rx_done) begin
            chal_d     = (chal_sr_q << BYTE_W) | CHAL_W'(bus.rx_data);
            chal_sr_d  = '0;
            byte_cnt_d = '0;
          end else begin
            chal_sr_d  = (chal_sr_q << BYTE_W) | CHAL_W'(bus.rx_data);
            byte_cnt_d = byte_cnt_q + 1'b1;
          end
        end else if ((RX_TIMEOUT != 0) && (byte_cnt_q != '0)) begin
          if (idle_q == IW'(RX_TIMEOUT - 1)) begin
            chal_sr_d  = '0;
            byte_cnt_d = '0;
          end else begin
            idle_d = idle_q + 1'b1;
          end
        end
      end
      S_PRE: begin
        phase_d = phase_last ? '0 : phase_q + 1'b1;
      end
      S_EVAL: begin
        phase_d = phase_last ? '0 : phase_q + 1'b1;
        if (phase_last) sample_d = sample_last ? '0 : sample_q + 1'b1;
      end
      S_VOTE: begin
        tx_sr_d  = majority;
        tx_cnt_d = '0;
      end
      S_TX: begin
        if (bus.tx_ready) begin
          tx_sr_d  = tx_sr_q >> BYTE_W;
          tx_cnt_d = tx_last ? '0 : tx_cnt_q + 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      byte_cnt_q <= '0;
      chal_sr_q  <= '0;
      chal_q     <= '0;
      phase_q    <= '0;
      sample_q   <= '0;
      tx_sr_q    <= '0;
      tx_cnt_q   <= '0;
      idle_q     <= '0;
      overrun_q  <= 1'b0;
    end else begin
      byte_cnt_q <= byte_cnt_d;
      chal_sr_q  <= chal_sr_d;
      chal_q     <= chal_d;
      phase_q    <= phase_d;
      sample_q   <= sample_d;
      tx_sr_q    <= tx_sr_d;
      tx_cnt_q   <= tx_cnt_d;
      idle_q     <= idle_d;
      overrun_q  <= overrun_d;
    end
  end

  assign bus.tx_valid      = tx_valid;
  assign bus.tx_data       = tx_sr_q[BYTE_W-1:0];
  assign bus.puf_challenge = chal_q;
  assign bus.puf_signal    = puf_signal;
  assign bus.busy          = busy;
  assign bus.overrun       = overrun_q;

endmodule

// File: tb/tb_puf_uart_sequencer.sv
// Self-checking bench: directed scenarios plus random challenges/samples against a majority model.
module tb_puf_uart_sequencer;

  localparam int unsigned CW  = 64;
  localparam int unsigned RW  = 64;
  localparam int unsigned ST  = 4;
  localparam int unsigned NS  = 3;
  localparam int unsigned TO  = 16;
  localparam int          LAT = NS * 2 * ST + 2;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  puf_uart_sequencer_if #(.CHAL_W(CW), .RESP_W(RW)) bus ();

  puf_uart_sequencer #(
    .CHAL_W        (CW),
    .RESP_W        (RW),
    .SETTLE_CYCLES (ST),
    .NUM_SAMPLES   (NS),
    .RX_TIMEOUT    (TO)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // PUF model: sample k of the current challenge returns samp[k].
  logic [RW-1:0] samp [NS];
  int evals   = 0;
  int base    = 0;
  int ovr_cnt = 0;
  int passed  = 0;
  int total   = 0;

  always @(negedge bus.puf_signal) evals++;
  always @(negedge clk) if (bus.overrun === 1'b1) ovr_cnt++;

  always_comb begin
    int idx;
    idx = evals - base;
    bus.puf_response = (idx >= 0 && idx < NS) ? samp[idx] : '0;
  end

  function automatic logic [RW-1:0] model_resp();
    logic [RW-1:0] r;
    r = '0;
    for (int b = 0; b < RW; b++) begin
      int ones;
      ones = 0;
      for (int k = 0; k < NS; k++) ones += int'(samp[k][b]);
      r[b] = (2 * ones > NS);
    end
    return r;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic send_byte(input logic [7:0] b);
    bus.rx_valid = 1'b1;
    bus.rx_data  = b;
    @(negedge clk);
    bus.rx_valid = 1'b0;
  endtask

  task automatic send_chal(input logic [CW-1:0] c);
    for (int i = CW / 8 - 1; i >= 0; i--) send_byte(c[i*8+:8]);
  endtask

  task automatic wait_tx(input string tag, input bit check_lat);
    int lat;
    lat = 1;
    while (bus.tx_valid !== 1'b1 && lat < 1000) begin
      @(negedge clk);
      lat++;
    end
    if (check_lat) check({tag, "_lat"}, 64'(lat), 64'(LAT));
    else check({tag, "_txv"}, 64'(bus.tx_valid), 64'd1);
  endtask

  task automatic collect(input string tag, input logic [RW-1:0] exp, input int nbytes,
                         input bit stall);
    for (int k = 0; k < nbytes; k++) begin
      if (stall) begin
        logic [7:0] first;
        bit stable;
        first  = bus.tx_data;
        stable = 1'b1;
        repeat (20) begin
          @(negedge clk);
          if (bus.tx_data !== first || bus.tx_valid !== 1'b1) stable = 1'b0;
        end
        check({tag, "_stable"}, 64'(stable), 64'd1);
      end
      check($sformatf("%s_byte%0d", tag, k), {55'd0, bus.tx_valid, bus.tx_data},
            {55'd0, 1'b1, exp[k*8+:8]});
      bus.tx_ready = 1'b1;
      @(negedge clk);
      bus.tx_ready = 1'b0;
    end
    if (nbytes == RW / 8) check({tag, "_done"}, {62'd0, bus.tx_valid, bus.busy}, 64'd0);
  endtask

  task automatic run_txn(input string tag, input logic [CW-1:0] c, input bit stall);
    base = evals;
    send_chal(c);
    check({tag, "_chal"}, bus.puf_challenge, c);
    wait_tx(tag, 1'b1);
    collect(tag, model_resp(), RW / 8, stall);
  endtask

  task automatic rand_samples();
    for (int k = 0; k < NS; k++) samp[k] = {$urandom, $urandom};
  endtask

  initial begin
    logic [CW-1:0] c;
    logic [CW-1:0] prev;
    int guard;
    int ovr0;

    bus.rx_valid = 1'b0;
    bus.rx_data  = '0;
    bus.tx_ready = 1'b0;
    for (int k = 0; k < NS; k++) samp[k] = '0;

    #1 rst_n = 1'b0;
    #1;
    check("rst_outs", {52'd0, bus.tx_valid, bus.tx_data, bus.puf_signal, bus.busy, bus.overrun},
          64'd0);
    check("rst_chal", bus.puf_challenge, 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Basic path: response is the inverted challenge.
    c = 64'h0102030405060708;
    for (int k = 0; k < NS; k++) samp[k] = ~c;
    run_txn("t1", c, 1'b0);

    // Majority over disagreeing samples.
    samp[0] = 64'hFF00FF00FF00FF00;
    samp[1] = 64'h0F0F0F0F0F0F0F0F;
    samp[2] = 64'hFF00FF00FF00FF00;
    run_txn("t2", {$urandom, $urandom}, 1'b0);

    // Random challenges and samples.
    for (int r = 0; r < 3; r++) begin
      rand_samples();
      run_txn($sformatf("rnd%0d", r), {$urandom, $urandom}, 1'b0);
    end

    // Back-pressure.
    rand_samples();
    run_txn("t3", {$urandom, $urandom}, 1'b1);

    // Overrun: bytes during evaluate are dropped and reported.
    rand_samples();
    c    = {$urandom, $urandom};
    base = evals;
    ovr0 = ovr_cnt;
    send_chal(c);
    for (int n = 0; n < 3; n++) begin
      guard = 0;
      while (bus.puf_signal !== 1'b1 && guard < 200) begin
        @(negedge clk);
        guard++;
      end
      send_byte(8'($urandom));
      guard = 0;
      while (bus.puf_signal !== 1'b0 && guard < 200) begin
        @(negedge clk);
        guard++;
      end
    end
    wait_tx("t4", 1'b0);
    check("t4_ovr", 64'(ovr_cnt - ovr0), 64'd3);
    check("t4_chal", bus.puf_challenge, c);
    collect("t4", model_resp(), RW / 8, 1'b0);

    // Timeout discards a partial challenge.
    prev = bus.puf_challenge;
    send_byte(8'hAA);
    send_byte(8'hBB);
    send_byte(8'hCC);
    repeat (20) @(negedge clk);
    check("t5_hold", bus.puf_challenge, prev);
    check("t5_idle", 64'(bus.busy), 64'd0);
    rand_samples();
    run_txn("t5", 64'h1112131415161718, 1'b0);

    // Reset in the middle of the response.
    rand_samples();
    c    = {$urandom, $urandom};
    base = evals;
    send_chal(c);
    wait_tx("t6", 1'b0);
    collect("t6", model_resp(), 2, 1'b0);
    rst_n = 1'b0;
    #1;
    check("t6_rst_outs", {52'd0, bus.tx_valid, bus.tx_data, bus.puf_signal, bus.busy, bus.overrun},
          64'd0);
    check("t6_rst_chal", bus.puf_challenge, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    rand_samples();
    run_txn("t6b", {$urandom, $urandom}, 1'b0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
